// File: rtl/cart_mem_pkg.sv
// cart_mem_bridge shared types: FSM states, request classes, pending slot.
// Used by cart_mem_trig and cart_mem_bridge.
package cart_mem_pkg;

    localparam int MEM_AW_DEF = 25;

    typedef enum logic [1:0] {
        IDLE,
        ROM_RD,
        RAM_RD,
        RAM_WR
    } state_t;

    typedef enum logic [1:0] {
        RC_ROM_RD,
        RC_RAM_RD,
        RC_RAM_WR
    } req_cls_t;

    typedef struct packed {
        logic                  valid;
        req_cls_t              cls;
        logic [MEM_AW_DEF-1:0] addr;
        logic [7:0]            din;
    } slot_t;

    // A queued write is never displaced by a later trigger.
    function automatic slot_t slot_put(slot_t s, slot_t c);
        if (!c.valid) return s;
        if (s.valid && s.cls == RC_RAM_WR) return s;
        return c;
    endfunction

    function automatic state_t cls_state(req_cls_t c);
        case (c)
            RC_ROM_RD: return ROM_RD;
            RC_RAM_RD: return RAM_RD;
            default:   return RAM_WR;
        endcase
    endfunction

endpackage

// File: rtl/cart_mem_trig.sv
// Strobe-to-trigger stage: write edge detect and address-change filters.
// CART_MEM_ROMCACHE_EN: ROM compare on the word tag and report word hits.
module cart_mem_trig
    import cart_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] rom_addr,
    input  logic        rom_ce_n,
    input  logic        rom_oe_n,
    input  logic        rom_word,
    input  logic [19:0] ram_addr,
    input  logic [7:0]  ram_din,
    input  logic        ram_ce_n,
    input  logic        ram_oe_n,
    input  logic        ram_we_n,
    output logic        rom_trig,
    output logic        rom_hit,
    output logic        rd_trig,
    output logic        wr_trig,
    output logic [23:0] rom_tgt,
    output logic [19:0] ram_tgt,
    output logic [7:0]  ram_wd
);

`ifdef CART_MEM_ROMCACHE_EN
    localparam int TAG_LO = 1;
`else
    localparam int TAG_LO = 0;
`endif

    logic [23:TAG_LO] rom_last;
    logic             rom_vld;
    logic [19:0]      rd_last;
    logic             rd_vld;
    logic             we_n_q;
    logic             rom_sel;
    logic             rom_same;

    assign rom_tgt  = {rom_addr[23:1], rom_addr[0] & ~rom_word};
    assign rom_sel  = ~rom_ce_n & ~rom_oe_n;
    assign rom_same = rom_vld && rom_last == rom_tgt[23:TAG_LO];
    assign rom_trig = rom_sel && !rom_same;

`ifdef CART_MEM_ROMCACHE_EN
    assign rom_hit = rom_sel && rom_same;
`else
    assign rom_hit = 1'b0;
`endif

    assign ram_tgt = ram_addr;
    assign ram_wd  = ram_din;
    assign wr_trig = we_n_q & ~ram_we_n & ~ram_ce_n;
    assign rd_trig = ~ram_ce_n & ~ram_oe_n
                   & (!rd_vld || rd_last != ram_addr);

    // Remember last requested addresses and the previous write strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_last <= '0;
            rom_vld  <= 1'b0;
            rd_last  <= '0;
            rd_vld   <= 1'b0;
            we_n_q   <= 1'b0;
        end else begin
            we_n_q <= ram_we_n;
            if (rom_trig) begin
                rom_last <= rom_tgt[23:TAG_LO];
                rom_vld  <= 1'b1;
            end
            if (rd_trig) begin
                rd_last <= ram_addr;
                rd_vld  <= 1'b1;
            end else if (wr_trig) begin
                rd_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cart_mem_bridge.sv
// Mapper ROM/BSRAM strobes to single-outstanding SDRAM req/ack port.
// CART_MEM_ROMCACHE_EN: skip ROM requests that hit the word in ROM_Q.
module cart_mem_bridge
    import cart_mem_pkg::*;
#(
    parameter int                MEM_AW     = MEM_AW_DEF,
    parameter logic [MEM_AW-1:0] BSRAM_BASE = 25'h1F0_0000
) (
    input  logic              MCLK,
    input  logic              RST_N,
    input  logic [23:0]       ROM_ADDR,
    input  logic              ROM_CE_N,
    input  logic              ROM_OE_N,
    input  logic              ROM_WORD,
    output logic [15:0]       ROM_Q,
    input  logic [19:0]       BSRAM_ADDR,
    input  logic [7:0]        BSRAM_D,
    input  logic              BSRAM_CE_N,
    input  logic              BSRAM_OE_N,
    input  logic              BSRAM_WE_N,
    output logic [7:0]        BSRAM_Q,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic [7:0]        MEM_DIN,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DOUT,
    output logic              BUSY,
    output logic              WR_OVF
);

    state_t                state, state_n;
    slot_t                 pend, pend_n, issue, base;
    slot_t                 rom_c, rd_c, wr_c;
    logic                  free, ovf_set;
    logic                  rom_trig, rom_hit, rd_trig, wr_trig;
    logic                  rom_lsb;
    logic [23:0]           rom_tgt;
    logic [19:0]           ram_tgt;
    logic [7:0]            ram_wd;
    logic [MEM_AW_DEF-1:0] ram_full;

    cart_mem_trig u_trig (
        .clk      (MCLK),
        .rst_n    (RST_N),
        .rom_addr (ROM_ADDR),
        .rom_ce_n (ROM_CE_N),
        .rom_oe_n (ROM_OE_N),
        .rom_word (ROM_WORD),
        .ram_addr (BSRAM_ADDR),
        .ram_din  (BSRAM_D),
        .ram_ce_n (BSRAM_CE_N),
        .ram_oe_n (BSRAM_OE_N),
        .ram_we_n (BSRAM_WE_N),
        .rom_trig (rom_trig),
        .rom_hit  (rom_hit),
        .rd_trig  (rd_trig),
        .wr_trig  (wr_trig),
        .rom_tgt  (rom_tgt),
        .ram_tgt  (ram_tgt),
        .ram_wd   (ram_wd)
    );

    assign ram_full = MEM_AW_DEF'(BSRAM_BASE + MEM_AW'(ram_tgt));

    // Pick what to issue, route losers to the slot, decide next state.
    always_comb begin
        rom_c   = '{valid: rom_trig, cls: RC_ROM_RD,
                    addr: {1'b0, rom_tgt}, din: 8'h00};
        rd_c    = '{valid: rd_trig, cls: RC_RAM_RD,
                    addr: ram_full, din: 8'h00};
        wr_c    = '{valid: wr_trig, cls: RC_RAM_WR,
                    addr: ram_full, din: ram_wd};
        base    = pend;
        issue   = '0;
        state_n = state;
        // The ack cycle counts as idle so a queued request chains with no gap.
        free    = (state == IDLE) || MEM_ACK;
        if (free) begin
            if (pend.valid) begin
                issue = pend;
                base  = '0;
            end else if (wr_c.valid) begin
                issue       = wr_c;
                wr_c.valid  = 1'b0;
            end else if (rom_c.valid) begin
                issue       = rom_c;
                rom_c.valid = 1'b0;
            end else if (rd_c.valid) begin
                issue       = rd_c;
                rd_c.valid  = 1'b0;
            end
        end
        ovf_set = wr_c.valid && base.valid && base.cls == RC_RAM_WR;
        pend_n  = slot_put(slot_put(slot_put(base, rd_c), rom_c), wr_c);
        if (issue.valid) begin
            state_n = cls_state(issue.cls);
        end else if (free) begin
            state_n = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge MCLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_n;
    end

    // Request outputs, pending slot, status and returned read data.
    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            pend     <= '0;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DIN  <= '0;
            BUSY     <= 1'b0;
            WR_OVF   <= 1'b0;
            ROM_Q    <= 16'hFFFF;
            BSRAM_Q  <= 8'hFF;
            rom_lsb  <= 1'b0;
        end else begin
            pend    <= pend_n;
            MEM_REQ <= state_n != IDLE;
            BUSY    <= (state_n != IDLE) || pend_n.valid;
            if (ovf_set) WR_OVF <= 1'b1;
            if (issue.valid) begin
                MEM_WE   <= issue.cls == RC_RAM_WR;
                MEM_ADDR <= MEM_AW'(issue.addr);
                MEM_DIN  <= issue.din;
            end
            if (state == ROM_RD && MEM_ACK) begin
                ROM_Q   <= MEM_ADDR[0] ? {MEM_DOUT[7:0], MEM_DOUT[15:8]}
                                       : MEM_DOUT;
                rom_lsb <= MEM_ADDR[0];
            end else if (rom_hit && rom_tgt[0] != rom_lsb) begin
                ROM_Q   <= {ROM_Q[7:0], ROM_Q[15:8]};
                rom_lsb <= rom_tgt[0];
            end
            if (state == RAM_RD && MEM_ACK) begin
                BSRAM_Q <= MEM_ADDR[0] ? MEM_DOUT[15:8] : MEM_DOUT[7:0];
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_bridge.sv
// Directed bench for cart_mem_bridge: ROM/BSRAM paths, chaining, reset.
// Follows CART_MEM_ROMCACHE_EN to pick the expected ROM repeat behaviour.
module tb_cart_mem_bridge;

    logic        MCLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [23:0] ROM_ADDR = '0;
    logic        ROM_CE_N = 1'b1;
    logic        ROM_OE_N = 1'b1;
    logic        ROM_WORD = 1'b0;
    logic [15:0] ROM_Q;
    logic [19:0] BSRAM_ADDR = '0;
    logic [7:0]  BSRAM_D = '0;
    logic        BSRAM_CE_N = 1'b1;
    logic        BSRAM_OE_N = 1'b1;
    logic        BSRAM_WE_N = 1'b1;
    logic [7:0]  BSRAM_Q;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [24:0] MEM_ADDR;
    logic [7:0]  MEM_DIN;
    logic        MEM_ACK = 1'b0;
    logic [15:0] MEM_DOUT = '0;
    logic        BUSY;
    logic        WR_OVF;

    int checks = 0;
    int fails = 0;
    int n_req = 0;
    logic req_prev = 1'b0;
    logic ack_prev = 1'b0;

    cart_mem_bridge dut (
        .MCLK       (MCLK),
        .RST_N      (RST_N),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_CE_N   (ROM_CE_N),
        .ROM_OE_N   (ROM_OE_N),
        .ROM_WORD   (ROM_WORD),
        .ROM_Q      (ROM_Q),
        .BSRAM_ADDR (BSRAM_ADDR),
        .BSRAM_D    (BSRAM_D),
        .BSRAM_CE_N (BSRAM_CE_N),
        .BSRAM_OE_N (BSRAM_OE_N),
        .BSRAM_WE_N (BSRAM_WE_N),
        .BSRAM_Q    (BSRAM_Q),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DIN    (MEM_DIN),
        .MEM_ACK    (MEM_ACK),
        .MEM_DOUT   (MEM_DOUT),
        .BUSY       (BUSY),
        .WR_OVF     (WR_OVF)
    );

    always #5 MCLK = ~MCLK;

    // A request starts when REQ rises or stays high straight after an ack.
    always @(posedge MCLK) begin
        if (MEM_REQ && (!req_prev || ack_prev)) n_req++;
        req_prev = MEM_REQ;
        ack_prev = MEM_ACK;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        tick(3);
        RST_N = 1'b1;
        tick();
        checks++;
        if (ROM_Q !== 16'hFFFF) begin
            fails++;
            $display("FAIL rst_rom_q got %h want ffff", ROM_Q);
        end
        checks++;
        if (BSRAM_Q !== 8'hFF) begin
            fails++;
            $display("FAIL rst_bsram_q got %h want ff", BSRAM_Q);
        end
        checks++;
        if ({MEM_REQ, MEM_WE, BUSY, WR_OVF} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_flags got %b want 0000",
                     {MEM_REQ, MEM_WE, BUSY, WR_OVF});
        end
        checks++;
        if (MEM_ADDR !== 25'h0 || MEM_DIN !== 8'h00) begin
            fails++;
            $display("FAIL rst_bus got %h/%h want 0/0", MEM_ADDR, MEM_DIN);
        end
    endtask

    task automatic test_rom_read;
        ROM_ADDR = 24'h012345;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1;
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0) begin
            fails++;
            $display("FAIL rom_req got %b%b want 10", MEM_REQ, MEM_WE);
        end
        checks++;
        if (MEM_ADDR !== 25'h0012345) begin
            fails++;
            $display("FAIL rom_addr got %h want 0012345", MEM_ADDR);
        end
        tick(2);
        MEM_DOUT = 16'hBEEF;
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        checks++;
        if (ROM_Q !== 16'hEFBE) begin
            fails++;
            $display("FAIL rom_q got %h want efbe", ROM_Q);
        end
        checks++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL rom_done got %b%b want 00", MEM_REQ, BUSY);
        end
    endtask

    task automatic test_rom_repeat;
        int n0;
        n0 = n_req;
        ROM_ADDR = 24'h012344;
        ROM_OE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1;
`ifdef CART_MEM_ROMCACHE_EN
        checks++;
        if (ROM_Q[7:0] !== 8'hEF) begin
            fails++;
            $display("FAIL rom_hit_q got %h want ef", ROM_Q[7:0]);
        end
        tick(2);
        checks++;
        if (MEM_REQ !== 1'b0 || n_req != n0) begin
            fails++;
            $display("FAIL rom_hit_req got %0d want 0", n_req - n0);
        end
`else
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== 25'h0012344) begin
            fails++;
            $display("FAIL rom_rep_req got %b/%h want 1/0012344",
                     MEM_REQ, MEM_ADDR);
        end
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        tick();
        checks++;
        if (ROM_Q !== 16'hBEEF || n_req != n0 + 1) begin
            fails++;
            $display("FAIL rom_rep_q got %h/%0d want beef/1",
                     ROM_Q, n_req - n0);
        end
`endif
        ROM_CE_N = 1'b1;
        tick();
    endtask

    task automatic test_bsram_write;
        int n0;
        n0 = n_req;
        BSRAM_ADDR = 20'h00010;
        BSRAM_D = 8'h5A;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        tick();
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1) begin
            fails++;
            $display("FAIL wr_req got %b%b want 11", MEM_REQ, MEM_WE);
        end
        checks++;
        if (MEM_ADDR !== 25'h1F00010 || MEM_DIN !== 8'h5A) begin
            fails++;
            $display("FAIL wr_bus got %h/%h want 1f00010/5a",
                     MEM_ADDR, MEM_DIN);
        end
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        tick(4);
        checks++;
        if (n_req != n0 + 1 || MEM_REQ !== 1'b0) begin
            fails++;
            $display("FAIL wr_once got %0d req want 1", n_req - n0);
        end
        BSRAM_WE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        tick();
    endtask

    task automatic test_bsram_read;
        int n0;
        BSRAM_ADDR = 20'h00011;
        BSRAM_CE_N = 1'b0;
        BSRAM_OE_N = 1'b0;
        tick();
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_ADDR !== 25'h1F00011) begin
            fails++;
            $display("FAIL rd_req got %b/%h want 1/1f00011",
                     MEM_REQ, MEM_ADDR);
        end
        MEM_DOUT = 16'h77CC;
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        checks++;
        if (BSRAM_Q !== 8'h77) begin
            fails++;
            $display("FAIL rd_q got %h want 77", BSRAM_Q);
        end
        n0 = n_req;
        tick(3);
        checks++;
        if (n_req != n0 || MEM_REQ !== 1'b0) begin
            fails++;
            $display("FAIL rd_same got %0d req want 0", n_req - n0);
        end
        BSRAM_OE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back;
        ROM_ADDR = 24'h020001;
        ROM_WORD = 1'b1;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1;
        ROM_CE_N = 1'b1;
        checks++;
        if (MEM_ADDR !== 25'h0020000 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL b2b_rom got %h/%b want 0020000/1", MEM_ADDR, BUSY);
        end
        BSRAM_ADDR = 20'h00020;
        BSRAM_D = 8'hA5;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        tick();
        checks++;
        if ({MEM_REQ, MEM_WE, BUSY} !== 3'b101) begin
            fails++;
            $display("FAIL b2b_hold got %b want 101", {MEM_REQ, MEM_WE, BUSY});
        end
        MEM_DOUT = 16'h1234;
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        ROM_WORD = 1'b0;
        checks++;
        if ({MEM_REQ, MEM_WE, BUSY} !== 3'b111) begin
            fails++;
            $display("FAIL b2b_chain got %b want 111", {MEM_REQ, MEM_WE, BUSY});
        end
        checks++;
        if (MEM_ADDR !== 25'h1F00020 || MEM_DIN !== 8'hA5) begin
            fails++;
            $display("FAIL b2b_wr got %h/%h want 1f00020/a5",
                     MEM_ADDR, MEM_DIN);
        end
        checks++;
        if (ROM_Q !== 16'h1234) begin
            fails++;
            $display("FAIL b2b_word got %h want 1234", ROM_Q);
        end
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        BSRAM_WE_N = 1'b1;
        BSRAM_CE_N = 1'b1;
        checks++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end got %b%b want 00", MEM_REQ, BUSY);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        ROM_ADDR = 24'h030000;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1;
        ROM_CE_N = 1'b1;
        checks++;
        if (MEM_REQ !== 1'b1) begin
            fails++;
            $display("FAIL mid_req got %b want 1", MEM_REQ);
        end
        RST_N = 1'b0;
        tick();
        checks++;
        if (MEM_REQ !== 1'b0 || ROM_Q !== 16'hFFFF || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst got %b/%h/%b want 0/ffff/0",
                     MEM_REQ, ROM_Q, BUSY);
        end
        RST_N = 1'b1;
        MEM_DOUT = 16'hABCD;
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        tick();
        checks++;
        if (ROM_Q !== 16'hFFFF || MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL mid_ack got %h/%b/%b want ffff/0/0",
                     ROM_Q, MEM_REQ, BUSY);
        end
        checks++;
        if (WR_OVF !== 1'b0) begin
            fails++;
            $display("FAIL mid_ovf got %b want 0", WR_OVF);
        end
    endtask

    task automatic test_wr_ovf;
        ROM_ADDR = 24'h040000;
        ROM_CE_N = 1'b0;
        ROM_OE_N = 1'b0;
        tick();
        ROM_OE_N = 1'b1;
        ROM_CE_N = 1'b1;
        BSRAM_ADDR = 20'h00001;
        BSRAM_D = 8'h11;
        BSRAM_CE_N = 1'b0;
        BSRAM_WE_N = 1'b0;
        tick();
        BSRAM_WE_N = 1'b1;
        tick();
        BSRAM_ADDR = 20'h00002;
        BSRAM_D = 8'h22;
        BSRAM_WE_N = 1'b0;
        tick();
        BSRAM_WE_N = 1'b1;
        checks++;
        if (WR_OVF !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag got %b want 1", WR_OVF);
        end
        checks++;
        if (MEM_ADDR !== 25'h0040000 || BUSY !== 1'b1) begin
            fails++;
            $display("FAIL ovf_hold got %h/%b want 0040000/1", MEM_ADDR, BUSY);
        end
        MEM_DOUT = 16'h0000;
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        checks++;
        if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 ||
            MEM_ADDR !== 25'h1F00001 || MEM_DIN !== 8'h11) begin
            fails++;
            $display("FAIL ovf_first got %b%b/%h/%h want 11/1f00001/11",
                     MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN);
        end
        MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        BSRAM_CE_N = 1'b1;
        tick();
        checks++;
        if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL ovf_drop got %b%b want 00", MEM_REQ, BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_rom_repeat();
        test_bsram_write();
        test_bsram_read();
        test_back_to_back();
        test_reset_mid();
        test_wr_ovf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 checks, fails);
        $finish;
    end

endmodule
